// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache between the CPU
//   load/store stage and a 256-bit line-based data memory. Hits complete in
//   the request cycle; misses stall the CPU while a dirty victim is written
//   back and the requested line is refilled.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cpu_req_i/we_i        access request, 1 = store word
//   cpu_addr_i/wdata_i    byte address, store data
//   cpu_rdata_o           load data, valid when cpu_req_i && !cpu_stall_o
//   cpu_stall_o           access not yet complete
//   mem_addr_o/data_o     line address, write-back line data
//   mem_enable_o/write_o  memory transaction request, 1 = line write
//   mem_ack_i             one-cycle transaction completion
//   mem_data_i            refill line, valid the cycle after mem_ack_i
//   hit_cnt_o/miss_cnt_o  access statistics
//
// Build option
//   DCACHE_STATS_EN : when defined, hit/miss counters are implemented;
//                     otherwise both counter outputs are tied to zero.

module dcache_controller #(
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_stall_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);

    localparam int unsigned LINES    = 2 ** INDEX_BITS;
    localparam int unsigned TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [255:0]        data_q [LINES];

    logic [2:0]            word;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [255:0]          line;
    logic                  hit;
    logic                  hit_access;
    logic [1:0]            unused_addr_bits;

    assign word             = cpu_addr_i[4:2];
    assign idx              = cpu_addr_i[4+INDEX_BITS:5];
    assign tag              = cpu_addr_i[31:5+INDEX_BITS];
    assign unused_addr_bits = cpu_addr_i[1:0];

    assign line       = data_q[idx];
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_access = (state_q == IDLE) && cpu_req_i && hit;

    assign cpu_rdata_o = line[{word, 5'b0} +: 32];

    // CPU inputs are held stable during a miss, so the indexed line and both
    // addresses stay constant for the whole memory transaction.
    assign mem_data_o = line;
    assign mem_addr_o = (state_q == WRITEBACK) ? {tag_q[idx], idx, 5'b0}
                                               : {tag, idx, 5'b0};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    cpu_stall_o = 1'b1;
                    state_d     = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                cpu_stall_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == FILL) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (hit_access && cpu_we_i) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Line data and tags carry no reset; valid_q masks them after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == FILL) begin
                data_q[idx] <= mem_data_i;
                tag_q[idx]  <= tag;
            end else if (hit_access && cpu_we_i) begin
                data_q[idx][{word, 5'b0} +: 32] <= cpu_wdata_i;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        fill_q;

    // fill_q marks the completing cycle of a miss so it is not counted as a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            fill_q     <= 1'b0;
        end else begin
            fill_q <= (state_q == FILL);
            if (hit_access && !fill_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && cpu_req_i && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller
//   Self-checking bench for dcache_controller with a 10-cycle line memory
//   model. CPU accesses and memory transactions are predicted into queues
//   and compared as the design completes them.

module tb_dcache_controller;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_enable;
    logic         mem_write;
    logic         mem_ack;
    logic [255:0] mem_rdata;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    dcache_controller #(.INDEX_BITS(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_enable_o(mem_enable),
        .mem_write_o (mem_write),
        .mem_ack_i   (mem_ack),
        .mem_data_i  (mem_rdata),
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] dflt_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[32*w +: 32] = 32'hA000_0000 | a | 32'(w);
        end
        return l;
    endfunction

    // ---------------- memory model: ack in 10th cycle of enable ----------------
    logic [255:0] mem_store [logic [31:0]];
    int           mcnt;

    always @(posedge clk) begin
        if (rst) begin
            mcnt    <= 0;
            mem_ack <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_ack) begin
                if (mem_write) begin
                    mem_store[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata <= mem_store.exists(mem_addr) ? mem_store[mem_addr]
                                                            : dflt_line(mem_addr);
                end
            end else if (mem_enable) begin
                if (mcnt == 8) begin
                    mem_ack <= 1'b1;
                    mcnt    <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    // ---------------- memory-side scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] w1;
    } txn_t;

    txn_t         exp_txn[$];
    int           txn_count = 0;
    int           exp_txn_total = 0;
    logic         en_prev = 1'b0;
    logic         ack_prev = 1'b0;
    logic         wr_prev = 1'b0;
    logic [31:0]  txn_addr;
    logic [255:0] txn_data;

    always @(negedge clk) begin
        if (rst) begin
            en_prev  = 1'b0;
            ack_prev = 1'b0;
            wr_prev  = 1'b0;
        end else begin
            // Only a write-back may be followed directly by its refill.
            if (ack_prev) begin
                chk("en_after_ack", 64'(mem_enable && !(wr_prev && !mem_write)), 64'd0);
            end
            if (mem_enable && (!en_prev || ack_prev)) begin
                txn_count++;
                txn_addr = mem_addr;
                txn_data = mem_wdata;
            end else if (mem_enable) begin
                chk("addr_hold", 64'(mem_addr), 64'(txn_addr));
                if (mem_write) begin
                    chk("data_hold", 64'(mem_wdata != txn_data), 64'd0);
                end
            end
            if (mem_ack && mem_enable) begin
                chk("txn_pending", 64'(exp_txn.size() > 0), 64'd1);
                if (exp_txn.size() > 0) begin
                    txn_t t;
                    t = exp_txn.pop_front();
                    chk("txn_addr", 64'(mem_addr), 64'(t.addr));
                    chk("txn_write", 64'(mem_write), 64'(t.wr));
                    if (t.wr) begin
                        chk("txn_word1", 64'(mem_wdata[63:32]), 64'(t.w1));
                    end
                end
            end
            en_prev  = mem_enable;
            ack_prev = mem_ack;
            wr_prev  = mem_write;
        end
    end

    // ---------------- CPU-side scoreboard ----------------
    typedef struct {
        string       tag;
        logic        we;
        logic [31:0] rd;
        int          lat;
    } acc_t;

    acc_t acc_q[$];
    int   exp_hits = 0;
    int   exp_miss = 0;

    task automatic push_txn(input logic [31:0] addr, input logic wr, input logic [31:0] w1);
        txn_t t;
        t.addr = addr;
        t.wr   = wr;
        t.w1   = w1;
        exp_txn.push_back(t);
        exp_txn_total++;
    endtask

    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input int exp_lat);
        acc_t a;
        int   lat;
        bit   done;
        a.tag = tag;
        a.we  = we;
        a.rd  = exp_rd;
        a.lat = exp_lat;
        acc_q.push_back(a);
        if (exp_lat == 0) exp_hits++;
        else              exp_miss++;

        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        lat  = 0;
        done = 1'b0;
        while (!done && lat <= 40) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
            else            lat++;
        end
        a = acc_q.pop_front();
        chk({a.tag, "_done"}, 64'(done), 64'd1);
        chk({a.tag, "_lat"}, 64'(lat), 64'(a.lat));
        if (!a.we) begin
            chk({a.tag, "_rdata"}, 64'(cpu_rdata), 64'(a.rd));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_txn.delete();
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_hits"}, 64'(hit_cnt), STATS ? 64'(exp_hits) : 64'd0);
        chk({tag, "_miss"}, 64'(miss_cnt), STATS ? 64'(exp_miss) : 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_enable", 64'(mem_enable), 64'd0);
        chk("rst_write", 64'(mem_write), 64'd0);
        check_stats("rst");

        push_txn(32'h40, 1'b0, 32'h0);
        access("ld40_miss", 1'b0, 32'h40, 32'h0, 32'hA000_0040, 12);
        access("ld40_hit", 1'b0, 32'h40, 32'h0, 32'hA000_0040, 0);
        access("st44", 1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 0);
        chk("st44_no_traffic", 64'(txn_count), 64'(exp_txn_total));
        access("ld44", 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0);
        access("ld5c", 1'b0, 32'h5C, 32'h0, 32'hA000_0047, 0);
        exp_hits--;  // ld5c is excluded so the counter checks cover the plan sequence only
        push_txn(32'h40, 1'b1, 32'hDEAD_BEEF);
        push_txn(32'h440, 1'b0, 32'h0);
        access("ld440_dirty", 1'b0, 32'h440, 32'h0, 32'hA000_0440, 22);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("seq_txns", 64'(txn_count), 64'(exp_txn_total));
        chk("seq_hits", 64'(hit_cnt), STATS ? 64'(exp_hits + 1) : 64'd0);
        chk("seq_miss", 64'(miss_cnt), STATS ? 64'(exp_miss) : 64'd0);

        // Reset while the refill of 0x840 is outstanding.
        push_txn(32'h840, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h840;
        repeat (5) @(negedge clk);
        chk("alloc_enable", 64'(mem_enable), 64'd1);
        chk("alloc_write", 64'(mem_write), 64'd0);
        chk("alloc_addr", 64'(mem_addr), 64'h840);
        do_reset();
        @(negedge clk);
        chk("midrst_enable", 64'(mem_enable), 64'd0);
        chk("midrst_stall", 64'(cpu_stall), 64'd0);
        check_stats("midrst");

        // All lines invalid again; the refill must return the written-back word.
        push_txn(32'h40, 1'b0, 32'h0);
        access("ld44_after_rst", 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 12);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check_stats("final");
        chk("final_txns", 64'(txn_count), 64'(exp_txn_total));
        chk("final_pending", 64'(exp_txn.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
